// File: rtl/prf_pkg.sv
// prf_pkg -- shared definitions for the physical register file.
//   * CLK_TRIGGER_EDGE  : clock edge used by every sequential block
//   * PRF_* localparams : default geometry of the register file
//   * prf_fsm_e         : post-reset clear sequencer states
//   * prf_addr_ok()     : true for a register that really exists (not 0, < depth)
`ifndef CLK_TRIGGER_EDGE
`define CLK_TRIGGER_EDGE posedge
`endif

package prf_pkg;

  localparam int PRF_WIDTH  = 32;
  localparam int PRF_DEPTH  = 64;
  localparam int PRF_NUM_RD = 8;
  localparam int PRF_NUM_WR = 4;
  localparam int PRF_NUM_AL = 2;

  typedef enum logic {
    PRF_FSM_INIT = 1'b0,
    PRF_FSM_RUN  = 1'b1
  } prf_fsm_e;

  // Register 0 is the hardwired zero; addresses past the end of a non-pow2
  // file alias onto it.
  function automatic logic prf_addr_ok(input int addr, input int depth);
    return (addr != 0) && (addr < depth);
  endfunction

endpackage

// File: rtl/prf_if.sv
// prf_if -- operand-read / writeback / allocate bundle of the register file.
//   master (rename/issue/CDB side): drives rd_addr, we, wr_addr, wr_data,
//                                   alloc_en, alloc_addr; sees rd_data,
//                                   rd_ready, init_busy
//   slave  (prf_bank)             : the reverse
// Port k of a bus sits at [k*AW +: AW] / [k*WIDTH +: WIDTH].
interface prf_if #(
  parameter int WIDTH  = prf_pkg::PRF_WIDTH,
  parameter int DEPTH  = prf_pkg::PRF_DEPTH,
  parameter int NUM_RD = prf_pkg::PRF_NUM_RD,
  parameter int NUM_WR = prf_pkg::PRF_NUM_WR,
  parameter int NUM_AL = prf_pkg::PRF_NUM_AL
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_ready;
  logic [NUM_WR-1:0]       we;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [NUM_AL-1:0]       alloc_en;
  logic [NUM_AL*AW-1:0]    alloc_addr;
  logic                    init_busy;

  modport master (
    output rd_addr, we, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_ready, init_busy
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_ready, init_busy
  );
endinterface

// File: rtl/prf_rd_port.sv
// prf_rd_port -- one combinational read port of the register file.
//   run        : file is out of its post-reset clear
//   addr       : register being read
//   file_data  : stored value of that register (pre-edge)
//   file_ready : stored ready bit of that register (pre-edge)
//   we/wr_addr/wr_data, alloc_en/alloc_addr : this cycle's writebacks and
//                allocations, used for same-cycle forwarding when BYPASS=1
//   data/ready : read result
module prf_rd_port import prf_pkg::*; #(
  parameter int WIDTH  = PRF_WIDTH,
  parameter int DEPTH  = PRF_DEPTH,
  parameter int NUM_WR = PRF_NUM_WR,
  parameter int NUM_AL = PRF_NUM_AL,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                          run,
  input  logic [AW-1:0]                 addr,
  input  logic [WIDTH-1:0]              file_data,
  input  logic                          file_ready,
  input  logic [NUM_WR-1:0]             we,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_data,
  input  logic [NUM_AL-1:0]             alloc_en,
  input  logic [NUM_AL-1:0][AW-1:0]     alloc_addr,
  output logic [WIDTH-1:0]              data,
  output logic                          ready
);

  logic hit;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // leaves a value held and no latch is inferred.
    data  = '0;
    ready = 1'b1;
    hit   = 1'b0;
    if (run && prf_addr_ok(int'(addr), DEPTH)) begin
      data  = file_data;
      ready = file_ready;
      if (BYPASS != 0) begin
        // Ascending scan: the highest-index matching writer is seen last.
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && (wr_addr[i] == addr)) begin
            data = wr_data[i];
            hit  = 1'b1;
          end
        end
        // A forwarded result is ready unless the register is being
        // re-allocated in the same cycle.
        if (hit) begin
          ready = 1'b1;
          for (int j = 0; j < NUM_AL; j++) begin
            if (alloc_en[j] && (alloc_addr[j] == addr)) ready = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/prf_bank.sv
// prf_bank -- parametrised physical register file with scoreboard bits.
//   clk : clock
//   rst : asynchronous, active-high reset; restarts the zero-clear sequence
//   bus : prf_if slave -- NUM_RD read ports, NUM_WR writeback ports,
//         NUM_AL allocation ports, init_busy while the file is being cleared
// Entry 0 reads as zero/ready. Writes set ready, allocations clear it, and an
// allocation beats a writeback to the same register in the same cycle.
module prf_bank import prf_pkg::*; #(
  parameter int WIDTH  = PRF_WIDTH,
  parameter int DEPTH  = PRF_DEPTH,
  parameter int NUM_RD = PRF_NUM_RD,
  parameter int NUM_WR = PRF_NUM_WR,
  parameter int NUM_AL = PRF_NUM_AL,
  parameter int BYPASS = 1
) (
  input logic  clk,
  input logic  rst,
  prf_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  prf_fsm_e                       state, state_nxt;
  logic [AW-1:0]                  init_cnt;
  logic                           run;
  logic [WIDTH-1:0]               file [DEPTH];
  logic [DEPTH-1:0]               ready;

  logic [NUM_RD-1:0][AW-1:0]      rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]   rd_data;
  logic [NUM_RD-1:0]              rd_ready;
  logic [NUM_WR-1:0][AW-1:0]      wr_addr;
  logic [NUM_WR-1:0][WIDTH-1:0]   wr_data;
  logic [NUM_AL-1:0][AW-1:0]      alloc_addr;
  logic [NUM_WR-1:0]              wr_ok;
  logic [NUM_AL-1:0]              al_ok;

  assign rd_addr       = bus.rd_addr;
  assign wr_addr       = bus.wr_addr;
  assign wr_data       = bus.wr_data;
  assign alloc_addr    = bus.alloc_addr;
  assign bus.rd_data   = rd_data;
  assign bus.rd_ready  = rd_ready;
  assign run           = (state == PRF_FSM_RUN);
  assign bus.init_busy = ~run;

  // ---------------- post-reset clear sequencer ----------------
  always_ff @(`CLK_TRIGGER_EDGE clk or posedge rst) begin
    if (rst) state <= PRF_FSM_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PRF_FSM_INIT: if (init_cnt == AW'(DEPTH - 1)) state_nxt = PRF_FSM_RUN;
      PRF_FSM_RUN:  state_nxt = PRF_FSM_RUN;
      default:      state_nxt = PRF_FSM_INIT;
    endcase
  end

  // Entry 0 is never stored, so the sweep starts at 1.
  always_ff @(`CLK_TRIGGER_EDGE clk or posedge rst) begin
    if (rst)      init_cnt <= AW'(1);
    else if (!run) init_cnt <= init_cnt + 1'b1;
  end

  // ---------------- write / allocate qualification ----------------
  always_comb begin
    wr_ok = '0;
    al_ok = '0;
    for (int i = 0; i < NUM_WR; i++)
      wr_ok[i] = bus.we[i] && prf_addr_ok(int'(wr_addr[i]), DEPTH);
    for (int j = 0; j < NUM_AL; j++)
      al_ok[j] = bus.alloc_en[j] && prf_addr_ok(int'(alloc_addr[j]), DEPTH);
  end

  // ---------------- storage ----------------
  // NOTE: the array has no reset term; the INIT sweep clears it, which keeps
  // it mappable onto plain RAM or reset-less flops.
  always_ff @(`CLK_TRIGGER_EDGE clk) begin
    if (!run) begin
      file[init_cnt] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++)
        if (wr_ok[i]) file[wr_addr[i]] <= wr_data[i];
    end
  end

  // ---------------- ready (scoreboard) bits ----------------
  // NOTE: non-blocking updates to the same bit resolve to the last one
  // executed, so the loop order encodes priority: higher write port over
  // lower, and any allocation over any write.
  always_ff @(`CLK_TRIGGER_EDGE clk or posedge rst) begin
    if (rst) begin
      ready <= '1;
    end else if (run) begin
      for (int i = 0; i < NUM_WR; i++)
        if (wr_ok[i]) ready[wr_addr[i]] <= 1'b1;
      for (int j = 0; j < NUM_AL; j++)
        if (al_ok[j]) ready[alloc_addr[j]] <= 1'b0;
    end
  end

  // ---------------- read ports ----------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    prf_rd_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .NUM_WR (NUM_WR),
      .NUM_AL (NUM_AL),
      .BYPASS (BYPASS),
      .AW     (AW)
    ) u_rd (
      .run        (run),
      .addr       (rd_addr[k]),
      .file_data  (file[rd_addr[k]]),
      .file_ready (ready[rd_addr[k]]),
      .we         (bus.we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alloc_en   (bus.alloc_en),
      .alloc_addr (alloc_addr),
      .data       (rd_data[k]),
      .ready      (rd_ready[k])
    );
  end

endmodule

// File: tb/tb_prf_bank.sv
// tb_prf_bank -- directed and randomized checks of prf_bank.
//   dut_a : default geometry, BYPASS=1
//   dut_b : default geometry, BYPASS=0, same stimulus as dut_a
//   dut_c : DEPTH=32, NUM_RD=4, NUM_WR=2, BYPASS=1, random traffic against a
//           behavioural model of the register file
`timescale 1ns/1ps
module tb_prf_bank;
  import prf_pkg::*;

  localparam int W     = 32;
  localparam int AW_A  = 6;
  localparam int NRD_A = 8;
  localparam int DEP_C = 32;
  localparam int AW_C  = 5;
  localparam int NRD_C = 4;
  localparam int NWR_C = 2;
  localparam int NAL   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prf_if if_a ();
  prf_if if_b ();
  prf_if #(.DEPTH(DEP_C), .NUM_RD(NRD_C), .NUM_WR(NWR_C)) if_c ();

  prf_bank #(.BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  prf_bank #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  prf_bank #(.DEPTH(DEP_C), .NUM_RD(NRD_C), .NUM_WR(NWR_C), .BYPASS(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  assign if_b.rd_addr    = if_a.rd_addr;
  assign if_b.we         = if_a.we;
  assign if_b.wr_addr    = if_a.wr_addr;
  assign if_b.wr_data    = if_a.wr_data;
  assign if_b.alloc_en   = if_a.alloc_en;
  assign if_b.alloc_addr = if_a.alloc_addr;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------- dut_a / dut_b stimulus helpers ----------
  task automatic a_clear();
    if_a.rd_addr = '0; if_a.we = '0; if_a.wr_addr = '0; if_a.wr_data = '0;
    if_a.alloc_en = '0; if_a.alloc_addr = '0;
  endtask
  task automatic a_wr(input int p, input int addr, input logic [W-1:0] d);
    if_a.we[p] = 1'b1;
    if_a.wr_addr[p*AW_A +: AW_A] = AW_A'(addr);
    if_a.wr_data[p*W +: W] = d;
  endtask
  task automatic a_al(input int p, input int addr);
    if_a.alloc_en[p] = 1'b1;
    if_a.alloc_addr[p*AW_A +: AW_A] = AW_A'(addr);
  endtask
  task automatic a_rd(input int p, input int addr);
    if_a.rd_addr[p*AW_A +: AW_A] = AW_A'(addr);
  endtask
  function automatic logic [W-1:0] a_data(input int p);
    return if_a.rd_data[p*W +: W];
  endfunction
  function automatic logic [W-1:0] b_data(input int p);
    return if_b.rd_data[p*W +: W];
  endfunction
  task automatic c_clear();
    if_c.rd_addr = '0; if_c.we = '0; if_c.wr_addr = '0; if_c.wr_data = '0;
    if_c.alloc_en = '0; if_c.alloc_addr = '0;
  endtask

  // One clock edge, returning at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts falling edges (starting now) at which dut_a reports init_busy.
  task automatic count_busy(output int n);
    n = 0;
    while (if_a.init_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------- reference model for dut_c ----------
  logic [W-1:0] m_mem [DEP_C];
  bit           m_rdy [DEP_C];
  int           m_init;

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEP_C - 1))
                                       : int'($urandom_range(0, 6));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    a_clear();
    c_clear();

    // ---- 1. reset and post-reset clear ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_rd(3, 17);
    #1;
    check("rst_busy_a", if_a.init_busy, 1);
    check("rst_busy_c", if_c.init_busy, 1);
    check("rst_data", a_data(3), 0);
    check("rst_ready", if_a.rd_ready[3], 1);
    rst = 1'b0;
    count_busy(n);
    check("init_len", n, 63);
    check("init_done_b", if_b.init_busy, 0);
    for (int base = 0; base < 8; base++) begin
      for (int k = 0; k < NRD_A; k++) a_rd(k, base * 8 + k);
      #1;
      for (int k = 0; k < NRD_A; k++) begin
        check($sformatf("clr_data[%0d]", base * 8 + k), a_data(k), 0);
        check($sformatf("clr_rdy[%0d]", base * 8 + k), if_a.rd_ready[k], 1);
      end
      @(negedge clk);
    end

    // ---- 2. simple write / read, write to register 0 ----
    a_clear();
    a_wr(0, 5, 32'hDEADBEEF);
    tick();
    a_clear();
    a_rd(0, 5);
    #1;
    check("wr5_data_a", a_data(0), 32'hDEADBEEF);
    check("wr5_rdy_a", if_a.rd_ready[0], 1);
    check("wr5_data_b", b_data(0), 32'hDEADBEEF);
    a_wr(0, 0, 32'hFFFFFFFF);
    a_rd(1, 0);
    #1;
    check("wr0_same_data", a_data(1), 0);
    check("wr0_same_rdy", if_a.rd_ready[1], 1);
    tick();
    a_clear();
    a_rd(1, 0);
    #1;
    check("wr0_next_data", a_data(1), 0);

    // ---- 3. write-write collision ----
    a_clear();
    a_wr(1, 9, 32'h11);
    a_wr(3, 9, 32'h33);
    a_rd(0, 9);
    #1;
    check("coll_byp_a", a_data(0), 32'h33);
    check("coll_byp_rdy_a", if_a.rd_ready[0], 1);
    check("coll_nobyp_b", b_data(0), 0);
    tick();
    a_clear();
    a_rd(0, 9);
    #1;
    check("coll_next_a", a_data(0), 32'h33);
    check("coll_next_b", b_data(0), 32'h33);

    // ---- 4. allocation and ready bits ----
    a_clear();
    a_al(0, 12);
    a_rd(0, 12);
    #1;
    check("al_same_rdy_a", if_a.rd_ready[0], 1);
    tick();
    a_clear();
    a_rd(0, 12);
    #1;
    check("al_next_rdy_a", if_a.rd_ready[0], 0);
    check("al_next_rdy_b", if_b.rd_ready[0], 0);
    a_wr(2, 12, 32'h55);
    #1;
    check("wb_byp_rdy_a", if_a.rd_ready[0], 1);
    check("wb_byp_data_a", a_data(0), 32'h55);
    check("wb_nobyp_rdy_b", if_b.rd_ready[0], 0);
    check("wb_nobyp_data_b", b_data(0), 0);
    tick();
    a_clear();
    a_rd(0, 12);
    #1;
    check("wb_next_rdy_a", if_a.rd_ready[0], 1);
    check("wb_next_data_a", a_data(0), 32'h55);
    check("wb_next_rdy_b", if_b.rd_ready[0], 1);
    a_al(1, 12);
    a_wr(0, 12, 32'h66);
    #1;
    check("alwb_byp_rdy_a", if_a.rd_ready[0], 0);
    check("alwb_byp_data_a", a_data(0), 32'h66);
    tick();
    a_clear();
    a_rd(0, 12);
    #1;
    check("alwb_next_rdy_a", if_a.rd_ready[0], 0);
    check("alwb_next_data_a", a_data(0), 32'h66);
    check("alwb_next_rdy_b", if_b.rd_ready[0], 0);
    a_al(0, 0);
    a_rd(1, 0);
    tick();
    a_clear();
    a_rd(1, 0);
    #1;
    check("al0_rdy", if_a.rd_ready[1], 1);

    // ---- 5. reset mid-RUN, then mid-INIT ----
    a_rd(0, 12);
    rst = 1'b1;
    #1;
    check("rerun_busy", if_a.init_busy, 1);
    check("rerun_data", a_data(0), 0);
    check("rerun_rdy", if_a.rd_ready[0], 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midinit_busy", if_a.init_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_wr(0, 5, 32'hAAAA);
    a_al(0, 9);
    count_busy(n);
    a_clear();
    check("reinit_len", n, 63);
    a_rd(0, 5);
    a_rd(1, 9);
    a_rd(2, 12);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reinit_data_a%0d", k), a_data(k), 0);
      check($sformatf("reinit_rdy_a%0d", k), if_a.rd_ready[k], 1);
      check($sformatf("reinit_data_b%0d", k), b_data(k), 0);
      check($sformatf("reinit_rdy_b%0d", k), if_b.rd_ready[k], 1);
    end
    @(negedge clk);

    // ---- 6. random traffic on dut_c against the model ----
    rst = 1'b1;
    c_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEP_C; i++) begin
      m_mem[i] = '0;
      m_rdy[i] = 1'b1;
    end
    m_init = DEP_C - 1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit            s_we [NWR_C];
      int            s_wa [NWR_C];
      logic [W-1:0]  s_wd [NWR_C];
      bit            s_ae [NAL];
      int            s_aa [NAL];
      int            ra;
      bit            busy;
      logic [W-1:0]  e_d;
      bit            e_r;
      bit            hit;

      rst = (cyc >= 5000 && cyc < 5002);
      for (int p = 0; p < NWR_C; p++) begin
        s_we[p] = bit'($urandom_range(0, 1));
        s_wa[p] = rnd_addr();
        s_wd[p] = $urandom;
        if_c.we[p] = s_we[p];
        if_c.wr_addr[p*AW_C +: AW_C] = AW_C'(s_wa[p]);
        if_c.wr_data[p*W +: W] = s_wd[p];
      end
      for (int j = 0; j < NAL; j++) begin
        s_ae[j] = ($urandom_range(0, 3) == 0);
        s_aa[j] = rnd_addr();
        if_c.alloc_en[j] = s_ae[j];
        if_c.alloc_addr[j*AW_C +: AW_C] = AW_C'(s_aa[j]);
      end
      for (int k = 0; k < NRD_C; k++)
        if_c.rd_addr[k*AW_C +: AW_C] = AW_C'(rnd_addr());
      #1;

      busy = rst || (m_init > 0);
      check("rnd_busy", if_c.init_busy, busy);
      for (int k = 0; k < NRD_C; k++) begin
        ra  = int'(if_c.rd_addr[k*AW_C +: AW_C]);
        e_d = '0;
        e_r = 1'b1;
        if (!busy && ra != 0) begin
          e_d = m_mem[ra];
          e_r = m_rdy[ra];
          hit = 1'b0;
          for (int p = 0; p < NWR_C; p++)
            if (s_we[p] && s_wa[p] == ra) begin e_d = s_wd[p]; hit = 1'b1; end
          if (hit) begin
            e_r = 1'b1;
            for (int j = 0; j < NAL; j++)
              if (s_ae[j] && s_aa[j] == ra) e_r = 1'b0;
          end
        end
        check($sformatf("rnd_data c%0d p%0d a%0d", cyc, k, ra),
              if_c.rd_data[k*W +: W], e_d);
        check($sformatf("rnd_rdy c%0d p%0d a%0d", cyc, k, ra),
              if_c.rd_ready[k], e_r);
      end

      @(posedge clk);
      if (rst) begin
        m_init = DEP_C - 1;
        for (int i = 0; i < DEP_C; i++) begin
          m_mem[i] = '0;
          m_rdy[i] = 1'b1;
        end
      end else if (m_init > 0) begin
        m_init--;
      end else begin
        for (int p = 0; p < NWR_C; p++)
          if (s_we[p] && s_wa[p] != 0) begin
            m_mem[s_wa[p]] = s_wd[p];
            m_rdy[s_wa[p]] = 1'b1;
          end
        for (int j = 0; j < NAL; j++)
          if (s_ae[j] && s_aa[j] != 0) m_rdy[s_aa[j]] = 1'b0;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
